ud_pulse_tx: RTL and testbench
==============================

Name: ud_pulse_tx

Overview:
- Transmit side of the UP/DOWN pulse channel that the OR-combining logic consumes.
- Accepts a command (pulse count, starting polarity) and emits an alternating, non-overlapping train of UP and DOWN pulses.
- Each pulse has a programmable width and is followed by a mandatory all-low guard gap.
- One instance drives one channel pair (e.g. A_UP/A_DOWN) feeding the combiner.

Parameters:
- PULSE_CYCLES, 10, width of each UP or DOWN pulse in clock cycles (>=1)
- GAP_CYCLES, 1, all-low guard cycles after every pulse (>=1)
- CNT_W, 8, width of pulse-count field

Ports:
- CLK  in  1  system clock, all logic rising-edge
- RST_N  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  block can accept a command
- CMD_COUNT  in  CNT_W  number of pulses to emit (0 allowed)
- CMD_FIRST_DOWN  in  1  0: first pulse is UP, 1: first pulse is DOWN
- ABORT  in  1  synchronous abort of a train in progress
- CH_UP  out  1  UP pulse line, registered
- CH_DOWN  out  1  DOWN pulse line, registered
- BUSY  out  1  train in progress
- DONE  out  1  one-cycle strobe at end of train

Behaviour:
- Reset (RST_N low, async): CH_UP=0, CH_DOWN=0, BUSY=0, DONE=0, CMD_READY=1, state IDLE, counters cleared.
- Command accept:
  - A command is accepted when CMD_VALID & CMD_READY are high at a rising edge.
  - CMD_READY=1 only in IDLE; it is a registered output.
- FSM states: IDLE, PULSE, GAP, FIN.
- IDLE:
  - On accept with CMD_COUNT>0: latch the count and polarity, go to PULSE.
  - The first pulse line rises in the cycle after the accept edge (latency 1).
  - Set BUSY=1 and CMD_READY=0.
  - On accept with CMD_COUNT=0: go to FIN. No pulse is emitted.
- PULSE:
  - The active line is held high for exactly PULSE_CYCLES cycles, then drops.
  - On dropping: decrement the remaining count and go to GAP.
- GAP:
  - Both lines are low for exactly GAP_CYCLES cycles.
  - When the gap ends: if remaining>0, toggle polarity and go to PULSE; otherwise go to FIN.
- FIN:
  - DONE=1 for one cycle.
  - Next cycle: IDLE, BUSY=0, CMD_READY=1.
- Pulse train length:
  - Total train = N*(PULSE_CYCLES+GAP_CYCLES) cycles from the first pulse rise to the DONE cycle.
  - The DONE cycle immediately follows the last gap.
- Polarity alternates strictly: UP, DOWN, UP, ... (or DOWN-first). It never repeats consecutively within a train.
- Invariants that must hold every cycle, including across reset and abort:
  - CH_UP & CH_DOWN is never 1.
  - A gap of at least GAP_CYCLES separates any fall on one line from a rise on the other.
- ABORT:
  - Sampled in PULSE or GAP.
  - In PULSE: drop the line next cycle, then run one full GAP, then FIN (DONE pulses).
  - In GAP: finish the current gap, then FIN.
  - Ignored in IDLE and FIN.
- CMD_VALID while busy: ignored and not queued. The upstream must hold it until CMD_READY.
- Reset mid-train: both lines go low immediately (async). No DONE is issued.
- Counter widths:
  - Width counter: clog2(PULSE_CYCLES+1).
  - Gap counter: clog2(GAP_CYCLES+1).
  - Remaining count: CNT_W bits.
  - CMD_COUNT = 2^CNT_W-1 must work with no wrap.

Decomposition:
- Shared package ud_pulse_pkg holds:
  - FSM state encoding (IDLE/PULSE/GAP/FIN localparams)
  - UP/DOWN polarity constants
  - default PULSE_CYCLES/GAP_CYCLES, also used by the combiner bench
- One sub-module, ud_interval_cnt:
  - loadable down-counter with a terminal-count flag
  - instantiated once, reloaded with PULSE_CYCLES or GAP_CYCLES per state

Test Plan:
- Basic train:
  - Stimulus: reset, then CMD_COUNT=7, FIRST_DOWN=0 (PULSE=10, GAP=1).
  - Required: UP,DOWN,UP,DOWN,UP,DOWN,UP, each pulse 10 cycles with 1 low cycle between; DONE 77 cycles after the first rise; BUSY high throughout.
- DOWN-first, single pulse:
  - Stimulus: CMD_COUNT=1, FIRST_DOWN=1.
  - Required: CH_DOWN high 10 cycles, CH_UP never high, DONE at cycle 12 after accept.
- Zero count:
  - Stimulus: CMD_COUNT=0.
  - Required: no pulse, DONE exactly 2 cycles after the accept edge, CMD_READY back high the next cycle.
- Abort:
  - Stimulus: CMD_COUNT=5, ABORT asserted in cycle 4 of the 2nd pulse.
  - Required: CH_DOWN falls the next cycle, one gap follows, DONE fires, only 2 pulses total.
- Async reset:
  - Stimulus: RST_N low mid-pulse, between clock edges.
  - Required: CH_UP/CH_DOWN go 0 immediately; after release CMD_READY=1 and no DONE.
- Continuous property checks over the run:
  - Stimulus: random commands with CMD_VALID held while busy.
  - Required: assert CH_UP&CH_DOWN==0 and minimum gap every cycle; no command accepted while BUSY=1.

Source files
------------

// File: rtl/ud_pulse_pkg.sv
// Shared definitions for the UP/DOWN pulse channel: FSM state encoding,
// polarity constants and the default timing used by transmitter and combiner.
package ud_pulse_pkg;

   // Transmitter FSM state encoding
   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_PULSE_ENC = 2'd1;
   localparam logic [1:0] ST_GAP_ENC   = 2'd2;
   localparam logic [1:0] ST_FIN_ENC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_PULSE = ST_PULSE_ENC,
      ST_GAP   = ST_GAP_ENC,
      ST_FIN   = ST_FIN_ENC
   } ud_state_t;

   // Polarity of a pulse; also the index of its line in a {DOWN, UP} pair
   localparam logic POL_UP   = 1'b0;
   localparam logic POL_DOWN = 1'b1;

   // Default channel timing, shared with the combiner bench
   localparam int unsigned UD_PULSE_CYCLES_DEF = 10;
   localparam int unsigned UD_GAP_CYCLES_DEF   = 1;
   localparam int unsigned UD_CNT_W_DEF        = 8;

   // Width of one counter that must hold either interval length
   function automatic int unsigned interval_w(input int unsigned pulse_cycles,
                                              input int unsigned gap_cycles);
      int unsigned pw;
      int unsigned gw;
      pw = $clog2(pulse_cycles + 1);
      gw = $clog2(gap_cycles + 1);
      return (pw > gw) ? pw : gw;
   endfunction

endpackage

// File: rtl/ud_interval_cnt.sv
// Loadable down-counter that times one FSM interval. Loading N-1 makes the
// terminal-count flag rise after the interval has lasted N cycles.
module ud_interval_cnt
   import ud_pulse_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         tc
);

   logic [W-1:0] count_reg;

   // Reload has priority; decrementing stops at zero so tc stays stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign count = count_reg;
   assign tc    = (count_reg == '0);

endmodule

// File: rtl/ud_pulse_tx.sv
// Transmit side of one UP/DOWN pulse channel. A command emits an alternating
// train of fixed-width pulses, each followed by an all-low guard gap, and
// finishes with a one-cycle DONE strobe. All outputs are registered.
module ud_pulse_tx
   import ud_pulse_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = UD_PULSE_CYCLES_DEF,
   parameter int unsigned GAP_CYCLES   = UD_GAP_CYCLES_DEF,
   parameter int unsigned CNT_W        = UD_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_first_down,
   input  logic             abort,
   output logic             ch_up,
   output logic             ch_down,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IW = interval_w(PULSE_CYCLES, GAP_CYCLES);

   // Interval counter reload values (an interval of N cycles loads N-1)
   localparam logic [IW-1:0] PULSE_LOAD = IW'(PULSE_CYCLES - 1);
   localparam logic [IW-1:0] GAP_LOAD   = IW'(GAP_CYCLES - 1);
   // A zero-count command spends two cycles in FIN: a settle cycle, then DONE
   localparam logic [IW-1:0] ZERO_LOAD  = IW'(1);
   localparam logic [IW-1:0] ONE_LEFT   = IW'(1);

   ud_state_t        state_reg, state_next;
   logic [CNT_W-1:0] rem_reg, rem_next;
   logic             pol_reg, pol_next;
   logic             abort_reg, abort_next;
   logic [1:0]       line_reg, line_next;     // index POL_UP / POL_DOWN
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             cmd_ready_reg, cmd_ready_next;

   logic             cnt_load;
   logic [IW-1:0]    cnt_load_val;
   logic             cnt_dec;
   logic [IW-1:0]    cnt_count;
   logic             cnt_tc;

   ud_interval_cnt #(
      .W (IW)
   ) u_interval_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (cnt_count),
      .tc       (cnt_tc)
   );

   // Next-state and next-output decode; outputs are the registered values
   // for the coming cycle so every line changes exactly on a clock edge
   always_comb begin
      state_next     = state_reg;
      rem_next       = rem_reg;
      pol_next       = pol_reg;
      abort_next     = abort_reg;
      line_next      = line_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      cmd_ready_next = cmd_ready_reg;
      cnt_load       = 1'b0;
      cnt_load_val   = '0;
      cnt_dec        = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_reg) begin
               busy_next      = 1'b1;
               cmd_ready_next = 1'b0;
               abort_next     = 1'b0;
               cnt_load       = 1'b1;
               if (cmd_count != '0) begin
                  state_next           = ST_PULSE;
                  rem_next             = cmd_count;
                  pol_next             = cmd_first_down;
                  line_next            = '0;
                  line_next[pol_next]  = 1'b1;
                  cnt_load_val         = PULSE_LOAD;
               end else begin
                  state_next   = ST_FIN;
                  cnt_load_val = ZERO_LOAD;
               end
            end
         end

         ST_PULSE: begin
            // An abort truncates the pulse; the guard gap still runs in full
            if (abort || cnt_tc) begin
               state_next   = ST_GAP;
               line_next    = '0;
               rem_next     = rem_reg - CNT_W'(1);
               abort_next   = abort_reg | abort;
               cnt_load     = 1'b1;
               cnt_load_val = GAP_LOAD;
            end else begin
               cnt_dec = 1'b1;
            end
         end

         ST_GAP: begin
            if (cnt_tc) begin
               if (abort_reg || abort || (rem_reg == '0)) begin
                  state_next   = ST_FIN;
                  done_next    = 1'b1;
                  cnt_load     = 1'b1;
                  cnt_load_val = '0;
               end else begin
                  state_next          = ST_PULSE;
                  pol_next            = ~pol_reg;
                  line_next           = '0;
                  line_next[pol_next] = 1'b1;
                  cnt_load            = 1'b1;
                  cnt_load_val        = PULSE_LOAD;
               end
            end else begin
               cnt_dec = 1'b1;
               if (abort) begin
                  abort_next = 1'b1;
               end
            end
         end

         ST_FIN: begin
            if (cnt_tc) begin
               state_next     = ST_IDLE;
               busy_next      = 1'b0;
               cmd_ready_next = 1'b1;
               abort_next     = 1'b0;
            end else begin
               cnt_dec   = 1'b1;
               done_next = (cnt_count == ONE_LEFT);
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops both lines immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         rem_reg       <= '0;
         pol_reg       <= POL_UP;
         abort_reg     <= 1'b0;
         line_reg      <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         cmd_ready_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         rem_reg       <= rem_next;
         pol_reg       <= pol_next;
         abort_reg     <= abort_next;
         line_reg      <= line_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         cmd_ready_reg <= cmd_ready_next;
      end
   end

   assign ch_up     = line_reg[POL_UP];
   assign ch_down   = line_reg[POL_DOWN];
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign cmd_ready = cmd_ready_reg;

endmodule

// File: tb/tb_ud_pulse_tx.sv
// Self-checking bench for ud_pulse_tx. Expected waveforms are derived from
// the train timing rules with plain arithmetic on the cycle index k, where
// k=1 is the cycle right after the accept edge.
module tb_ud_pulse_tx;

   localparam int P      = 10;
   localparam int G      = 1;
   localparam int CW     = 8;
   localparam int PERIOD = P + G;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_count = '0;
   logic          cmd_first_down = 1'b0;
   logic          abort = 1'b0;
   logic          ch_up;
   logic          ch_down;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int txn    = 0;
   int low_run = 1000;
   bit prev_hi = 1'b0;

   always #5 clk = ~clk;

   ud_pulse_tx #(
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_count      (cmd_count),
      .cmd_first_down (cmd_first_down),
      .abort          (abort),
      .ch_up          (ch_up),
      .ch_down        (ch_down),
      .busy           (busy),
      .done           (done)
   );

   // Issue one command and check every cycle up to the cycle after DONE.
   // ac: cycle index during which ABORT is held high (0 = none).
   // hold: keep CMD_VALID high with junk fields while the train runs.
   task automatic run_cmd(input int n, input bit fd, input int ac,
                          input bit hold, input string name);
      int done_c;
      int last_hi;
      int exp_pulses;
      int obs_pulses;
      int waitc;
      int j;
      int off;
      bit e_hi;
      bit e_up;
      bit e_dn;
      bit hi;

      // Reference timing
      last_hi = 1 << 30;
      if (n == 0) begin
         done_c     = 2;
         exp_pulses = 0;
      end else begin
         done_c     = n * PERIOD + 1;
         exp_pulses = n;
         if (ac > 0 && ac < done_c) begin
            j   = (ac - 1) / PERIOD;
            off = (ac - 1) % PERIOD;
            if (off < P) begin
               done_c  = ac + G + 1;
               last_hi = ac;
            end else begin
               done_c = (j + 1) * PERIOD + 1;
            end
            exp_pulses = j + 1;
         end
      end

      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
         return;
      end

      cmd_valid      = 1'b1;
      cmd_count      = CW'(n);
      cmd_first_down = fd;
      @(posedge clk);
      obs_pulses = 0;

      for (int k = 1; k <= done_c + 1; k++) begin
         @(negedge clk);
         j    = (k - 1) / PERIOD;
         off  = (k - 1) % PERIOD;
         e_hi = (n > 0) && (k < done_c) && (off < P) && (j < n) && (k <= last_hi);
         e_dn = e_hi && (fd ^ j[0]);
         e_up = e_hi && !(fd ^ j[0]);

         checks++;
         if (ch_up !== e_up) begin
            errors++;
            $display("FAIL %s ch_up k=%0d: got %b required %b", name, k, ch_up, e_up);
         end
         checks++;
         if (ch_down !== e_dn) begin
            errors++;
            $display("FAIL %s ch_down k=%0d: got %b required %b", name, k, ch_down, e_dn);
         end
         checks++;
         if (done !== (k == done_c)) begin
            errors++;
            $display("FAIL %s done k=%0d: got %b required %b", name, k, done, (k == done_c));
         end
         checks++;
         if (busy !== (k <= done_c)) begin
            errors++;
            $display("FAIL %s busy k=%0d: got %b required %b", name, k, busy, (k <= done_c));
         end
         checks++;
         if (cmd_ready !== (k > done_c)) begin
            errors++;
            $display("FAIL %s cmd_ready k=%0d: got %b required %b", name, k, cmd_ready, (k > done_c));
         end
         checks++;
         if (ch_up === 1'b1 && ch_down === 1'b1) begin
            errors++;
            $display("FAIL %s overlap k=%0d: up&down=1 required 0", name, k);
         end

         hi = (ch_up === 1'b1) || (ch_down === 1'b1);
         if (hi && !prev_hi) begin
            obs_pulses++;
            checks++;
            if (low_run < G) begin
               errors++;
               $display("FAIL %s min_gap k=%0d: gap %0d required >= %0d", name, k, low_run, G);
            end
         end
         low_run = hi ? 0 : low_run + 1;
         prev_hi = hi;

         abort = (k == ac);
         if (hold && k < done_c) begin
            cmd_valid      = 1'b1;
            cmd_count      = CW'($urandom);
            cmd_first_down = 1'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      abort = 1'b0;

      checks++;
      if (obs_pulses != exp_pulses) begin
         errors++;
         $display("FAIL %s pulse_count: got %0d required %0d", name, obs_pulses, exp_pulses);
      end
      txn++;
      $display("txn %0d %s: count=%0d first_down=%0d abort_cycle=%0d hold=%0d pulses=%0d done_cycle=%0d",
               txn, name, n, fd, ac, hold, obs_pulses, done_c);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (ch_up !== 1'b0 || ch_down !== 1'b0) begin
         errors++;
         $display("FAIL reset_lines: up=%b down=%b required 0 0", ch_up, ch_down);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: busy=%b done=%b required 0 0", busy, done);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || ch_up !== 1'b0 || ch_down !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b busy=%b up=%b down=%b required 1 0 0 0",
                  cmd_ready, busy, ch_up, ch_down);
      end
      $display("txn - reset: outputs idle after reset release");
   endtask

   task automatic test_basic_train();
      run_cmd(7, 1'b0, 0, 1'b0, "basic_train");
   endtask

   task automatic test_single_down();
      run_cmd(1, 1'b1, 0, 1'b0, "single_down");
   endtask

   task automatic test_zero_count();
      run_cmd(0, 1'b0, 0, 1'b0, "zero_count");
   endtask

   task automatic test_abort();
      // Cycle 4 of the 2nd pulse (2nd pulse starts at k = PERIOD + 1)
      run_cmd(5, 1'b0, PERIOD + 4, 1'b0, "abort_pulse");
      run_cmd(4, 1'b1, 2 * PERIOD, 1'b0, "abort_gap");
      run_cmd(3, 1'b0, P, 1'b0, "abort_last_cycle");
   endtask

   task automatic test_max_count();
      run_cmd((1 << CW) - 1, 1'b0, 0, 1'b1, "max_count");
   endtask

   task automatic test_async_reset();
      int waitc;
      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      cmd_valid      = 1'b1;
      cmd_count      = CW'(3);
      cmd_first_down = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         checks++;
         if (ch_up !== 1'b1) begin
            errors++;
            $display("FAIL async_pre k=%0d: ch_up=%b required 1", k, ch_up);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ch_up !== 1'b0 || ch_down !== 1'b0) begin
         errors++;
         $display("FAIL async_lines: up=%b down=%b required 0 0", ch_up, ch_down);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_status: busy=%b done=%b ready=%b required 0 0 1", busy, done, cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || ch_up !== 1'b0 || ch_down !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_after k=%0d: done=%b up=%b down=%b ready=%b required 0 0 0 1",
                     k, done, ch_up, ch_down, cmd_ready);
         end
      end
      prev_hi = 1'b0;
      low_run = 1000;
      $display("txn - async_reset: lines cleared mid-pulse, no DONE after release");
   endtask

   task automatic test_random();
      int n;
      int ac;
      bit fd;
      bit hold;
      for (int t = 0; t < 25; t++) begin
         n    = $urandom_range(0, 14);
         fd   = 1'($urandom);
         hold = 1'($urandom);
         ac   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * PERIOD + 1) : 0;
         run_cmd(n, fd, ac, hold, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic_train();
      test_single_down();
      test_zero_count();
      test_abort();
      test_async_reset();
      test_random();
      test_max_count();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
